// File: rtl/s_cnt_pkg.sv
// Shared constants and types for the multi-channel event counter.
// Mode encodings and the default channel count width.
package s_cnt_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/s_cnt_mc_ch.sv
// One counter channel: count register, next-state, compare, wrap pulse.
// Optional load path is present when S_CNT_MC_LOAD_EN is defined.
module s_cnt_ch
  import s_cnt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic         e_cnt,
  input  logic         clear,
  input  logic         mode_sat,
  input  logic [W-1:0] limit,
`ifdef S_CNT_MC_LOAD_EN
  input  logic         load,
  input  logic [W-1:0] ld_val,
`endif
  output logic [W-1:0] count,
  output logic         tc,
  output logic         wrap_p
);

  logic [W-1:0] nxt;
  logic         nxt_wp;
  logic         adv;
  logic         at_lim;

  assign adv    = go & e_cnt;
  assign at_lim = (count >= limit);
  assign tc     = (count == limit);

  // Next count and wrap pulse: clear > load > advance > hold.
  always_comb begin
    nxt    = count;
    nxt_wp = 1'b0;
    if (clear) begin
      nxt = '0;
`ifdef S_CNT_MC_LOAD_EN
    end else if (load) begin
      nxt = ld_val;
`endif
    end else if (adv) begin
      if (!at_lim) begin
        nxt = count + 1'b1;
      end else if (mode_sat == MODE_SAT) begin
        nxt = limit;
      end else begin
        nxt    = '0;
        nxt_wp = 1'b1;
      end
    end
  end

  // Count and wrap pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wrap_p <= 1'b0;
    end else begin
      count  <= nxt;
      wrap_p <= nxt_wp;
    end
  end

endmodule

// File: rtl/s_cnt_mc.sv
// Multi-channel event counter: N_CH independent wrap/saturate channels.
// Define S_CNT_MC_LOAD_EN to add the load / ld_val preset ports.
module s_cnt_mc
  import s_cnt_pkg::*;
#(
  parameter int SIZECOUNT = CNT_W,
  parameter int N_CH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           go,
  input  logic [N_CH-1:0]           e_cnt,
  input  logic [N_CH-1:0]           clear,
  input  logic [N_CH-1:0]           mode_sat,
  input  logic [N_CH*SIZECOUNT-1:0] limit,
`ifdef S_CNT_MC_LOAD_EN
  input  logic [N_CH-1:0]           load,
  input  logic [N_CH*SIZECOUNT-1:0] ld_val,
`endif
  output logic [N_CH*SIZECOUNT-1:0] count,
  output logic [N_CH-1:0]           tc,
  output logic [N_CH-1:0]           wrap_p
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    s_cnt_ch #(
      .W(SIZECOUNT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .go      (go[i]),
      .e_cnt   (e_cnt[i]),
      .clear   (clear[i]),
      .mode_sat(mode_sat[i]),
      .limit   (limit[i*SIZECOUNT +: SIZECOUNT]),
`ifdef S_CNT_MC_LOAD_EN
      .load    (load[i]),
      .ld_val  (ld_val[i*SIZECOUNT +: SIZECOUNT]),
`endif
      .count   (count[i*SIZECOUNT +: SIZECOUNT]),
      .tc      (tc[i]),
      .wrap_p  (wrap_p[i])
    );
  end

endmodule
